// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: frame geometry, CRC7 polynomial and the
// command-engine state encoding used by both the host engine and the card model.
package sd_pkg;

  localparam int unsigned CMD_LEN   = 48;
  localparam logic [6:0]  CRC7_POLY = 7'h09;

  // Frame field bit positions (bit 47 is transmitted first)
  localparam int unsigned START_BIT = 47;
  localparam int unsigned TX_BIT    = 46;
  localparam int unsigned IDX_MSB   = 45;
  localparam int unsigned IDX_LSB   = 40;
  localparam int unsigned ARG_MSB   = 39;
  localparam int unsigned ARG_LSB   = 8;
  localparam int unsigned CRC_MSB   = 7;
  localparam int unsigned CRC_LSB   = 1;
  localparam int unsigned END_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WAIT_RSP,
    ST_GAP,
    ST_SEND
  } sd_state_e;

  // One serial step of CRC7 (x^7 + x^3 + 1)
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 generator. iclr restarts from zero; with ien in the same cycle
// the new bit is folded into the cleared register.
module crc7
  import sd_pkg::*;
(
  input  logic       iclk,
  input  logic       irst,
  input  logic       iclr,
  input  logic       ien,
  input  logic       ibit,
  output logic [6:0] ocrc
);

  logic [6:0] base_c;

  assign base_c = iclr ? 7'h00 : ocrc;

  always_ff @(posedge iclk) begin
    if (irst) begin
      ocrc <= 7'h00;
    end else if (ien) begin
      ocrc <= crc7_step(base_c, ibit);
    end else if (iclr) begin
      ocrc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: decodes host commands, sends short responses.
// Define CMD_CRC_CHECK_EN to validate the received CRC7 as well as the end bit.
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int unsigned NCR         = 2,
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd_sd,
  output logic        ocmd_sd,
  output logic        ocmd_sd_en,
  output logic        ocmd_valid,
  output logic [5:0]  ocmd_idx,
  output logic [31:0] ocmd_arg,
  output logic        ocrc_err,
  input  logic        irsp_valid,
  input  logic        irsp_none,
  input  logic [31:0] irsp_status,
  output logic        obusy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RXW   = IDX_MSB - ARG_LSB + 1;
  localparam int unsigned TXW   = CMD_LEN - ARG_LSB;

  sd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RXW-1:0]    rx_sr_q, rx_sr_d;
  logic [31:0]       status_q, status_d;
  logic              ocmd_sd_d, ocmd_sd_en_d, ocmd_valid_d, ocrc_err_d, obusy_d;
  logic [5:0]        ocmd_idx_d;
  logic [31:0]       ocmd_arg_d;
  logic              rx_ok_c;
  logic [5:0]        nb_c;
  logic [TXW-1:0]    tx_word_c;
  logic              tx_crc_clr_c, tx_crc_en_c, tx_crc_bit_c;
  logic [6:0]        tx_crc;

  assign tx_word_c = {2'b00, ocmd_idx, status_q};

`ifdef CMD_CRC_CHECK_EN
  // Receive CRC over bits 47..8; received CRC field captured separately
  logic [6:0] rx_crc, rx_crc_sr_q, rx_crc_sr_d;
  logic       rx_crc_clr_c, rx_crc_en_c;

  assign rx_crc_clr_c = (state_q == ST_IDLE);
  assign rx_crc_en_c  = rx_crc_clr_c || (state_q == ST_RECV && cnt_q >= CNT_W'(ARG_LSB));
  assign rx_crc_sr_d  = (state_q == ST_RECV && cnt_q >= CNT_W'(CRC_LSB) && cnt_q <= CNT_W'(CRC_MSB))
                        ? {rx_crc_sr_q[5:0], icmd_sd} : rx_crc_sr_q;

  always_ff @(posedge iclk) begin
    if (irst) rx_crc_sr_q <= 7'h00;
    else      rx_crc_sr_q <= rx_crc_sr_d;
  end

  crc7 u_rx_crc (
    .iclk (iclk),
    .irst (irst),
    .iclr (rx_crc_clr_c),
    .ien  (rx_crc_en_c),
    .ibit (icmd_sd),
    .ocrc (rx_crc)
  );

  assign rx_ok_c = icmd_sd && (rx_crc_sr_q == rx_crc);
`else
  assign rx_ok_c = icmd_sd;
`endif

  crc7 u_tx_crc (
    .iclk (iclk),
    .irst (irst),
    .iclr (tx_crc_clr_c),
    .ien  (tx_crc_en_c),
    .ibit (tx_crc_bit_c),
    .ocrc (tx_crc)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_sr_d      = rx_sr_q;
    status_d     = status_q;
    ocmd_sd_d    = 1'b1;
    ocmd_sd_en_d = 1'b0;
    ocmd_valid_d = 1'b0;
    ocrc_err_d   = 1'b0;
    ocmd_idx_d   = ocmd_idx;
    ocmd_arg_d   = ocmd_arg;
    tx_crc_clr_c = 1'b0;
    tx_crc_en_c  = 1'b0;
    tx_crc_bit_c = 1'b0;
    nb_c         = 6'(cnt_q) - 6'd1;

    case (state_q)
      ST_IDLE: begin
        if (!icmd_sd) begin
          state_d = ST_RECV;
          cnt_d   = CNT_W'(TX_BIT);
        end
      end

      ST_RECV: begin
        if (cnt_q >= CNT_W'(ARG_LSB) && cnt_q <= CNT_W'(IDX_MSB)) begin
          rx_sr_d = {rx_sr_q[RXW-2:0], icmd_sd};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(TX_BIT) && !icmd_sd) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(END_BIT)) begin
          state_d = ST_CHECK;
          if (rx_ok_c) begin
            ocmd_valid_d = 1'b1;
            ocmd_idx_d   = rx_sr_q[IDX_MSB-ARG_LSB:IDX_LSB-ARG_LSB];
            ocmd_arg_d   = rx_sr_q[ARG_MSB-ARG_LSB:0];
          end else begin
            ocrc_err_d = 1'b1;
          end
        end
      end

      // The user decision is already sampled in the CHECK cycle
      ST_CHECK, ST_WAIT_RSP: begin
        if (state_q == ST_CHECK && ocrc_err) begin
          state_d = ST_IDLE;
        end else if (irsp_valid) begin
          if (irsp_none) begin
            state_d = ST_IDLE;
          end else begin
            status_d = irsp_status;
            state_d  = ST_GAP;
            cnt_d    = '0;
          end
        end else if (state_q == ST_CHECK) begin
          state_d = ST_WAIT_RSP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(NCR - 1)) begin
          state_d      = ST_SEND;
          cnt_d        = CNT_W'(START_BIT);
          ocmd_sd_en_d = 1'b1;
          ocmd_sd_d    = tx_word_c[TXW-1];
          tx_crc_clr_c = 1'b1;
          tx_crc_en_c  = 1'b1;
          tx_crc_bit_c = tx_word_c[TXW-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // cnt_q is the frame bit currently on the line
      ST_SEND: begin
        if (cnt_q == CNT_W'(END_BIT)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d        = cnt_q - CNT_W'(1);
          ocmd_sd_en_d = 1'b1;
          if (nb_c >= 6'(ARG_LSB)) begin
            ocmd_sd_d    = tx_word_c[nb_c - 6'(ARG_LSB)];
            tx_crc_en_c  = 1'b1;
            tx_crc_bit_c = ocmd_sd_d;
          end else if (nb_c <= 6'(CRC_MSB) && nb_c >= 6'(CRC_LSB)) begin
            ocmd_sd_d = tx_crc[3'(nb_c - 6'(CRC_LSB))];
          end else if (nb_c == 6'(END_BIT)) begin
            ocmd_sd_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    obusy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      status_q   <= '0;
      ocmd_sd    <= 1'b1;
      ocmd_sd_en <= 1'b0;
      ocmd_valid <= 1'b0;
      ocrc_err   <= 1'b0;
      ocmd_idx   <= '0;
      ocmd_arg   <= '0;
      obusy      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      status_q   <= status_d;
      ocmd_sd    <= ocmd_sd_d;
      ocmd_sd_en <= ocmd_sd_en_d;
      ocmd_valid <= ocmd_valid_d;
      ocrc_err   <= ocrc_err_d;
      ocmd_idx   <= ocmd_idx_d;
      ocmd_arg   <= ocmd_arg_d;
      obusy      <= obusy_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed self-checking bench for sd_cmd_responder (NCR=2, RSP_TIMEOUT=64).
module tb_sd_cmd_responder;

  localparam int unsigned NCR         = 2;
  localparam int unsigned RSP_TIMEOUT = 64;

  logic        iclk = 1'b0;
  logic        irst, icmd_sd, irsp_valid, irsp_none;
  logic [31:0] irsp_status;
  logic        ocmd_sd, ocmd_sd_en, ocmd_valid, ocrc_err, obusy;
  logic [5:0]  ocmd_idx;
  logic [31:0] ocmd_arg;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   n_err    = 0;
  int   n_en_rise = 0;
  logic en_prev  = 1'b0;

  always #5 iclk = ~iclk;

  sd_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .icmd_sd     (icmd_sd),
    .ocmd_sd     (ocmd_sd),
    .ocmd_sd_en  (ocmd_sd_en),
    .ocmd_valid  (ocmd_valid),
    .ocmd_idx    (ocmd_idx),
    .ocmd_arg    (ocmd_arg),
    .ocrc_err    (ocrc_err),
    .irsp_valid  (irsp_valid),
    .irsp_none   (irsp_none),
    .irsp_status (irsp_status),
    .obusy       (obusy)
  );

  // Pulse and drive-enable event counters
  always @(negedge iclk) begin
    if (ocmd_valid) n_valid <= n_valid + 1;
    if (ocrc_err) n_err <= n_err + 1;
    if (ocmd_sd_en && !en_prev) n_en_rise <= n_en_rise + 1;
    en_prev <= ocmd_sd_en;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Leaves the bench in the cycle right after the end bit was sampled
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      icmd_sd = f[i];
      tick();
    end
    icmd_sd = 1'b1;
  endtask

  task automatic respond(input logic none, input logic [31:0] status);
    irsp_valid  = 1'b1;
    irsp_none   = none;
    irsp_status = status;
    tick();
    irsp_valid  = 1'b0;
    irsp_none   = 1'b0;
  endtask

  initial begin
    logic [47:0] rsp;
    logic [47:0] exp_frame;
    int          en_cycles;
    int          snap_a, snap_b;

    irst = 1'b1; icmd_sd = 1'b1; irsp_valid = 1'b0; irsp_none = 1'b0; irsp_status = '0;
    repeat (3) tick();
    check_eq("rst_sd",    64'(ocmd_sd), 64'd1);
    check_eq("rst_en",    64'(ocmd_sd_en), 64'd0);
    check_eq("rst_valid", 64'(ocmd_valid), 64'd0);
    check_eq("rst_idx",   64'(ocmd_idx), 64'd0);
    check_eq("rst_arg",   64'(ocmd_arg), 64'd0);
    check_eq("rst_err",   64'(ocrc_err), 64'd0);
    check_eq("rst_busy",  64'(obusy), 64'd0);
    irst = 1'b0;
    repeat (2) tick();

    // CMD0, no response
    send_frame(48'h400000000095);
    check_eq("cmd0_valid", 64'(ocmd_valid), 64'd1);
    check_eq("cmd0_idx",   64'(ocmd_idx), 64'd0);
    check_eq("cmd0_arg",   64'(ocmd_arg), 64'd0);
    check_eq("cmd0_busy",  64'(obusy), 64'd1);
    snap_a = n_en_rise;
    respond(1'b1, 32'h0);
    check_eq("cmd0_idle", 64'(obusy), 64'd0);
    repeat (10) tick();
    check_eq("cmd0_no_drive", 64'(n_en_rise), 64'(snap_a));

    // CMD8 with R7 response accepted in the CHECK cycle
    send_frame(48'h48000001AA87);
    check_eq("cmd8_valid", 64'(ocmd_valid), 64'd1);
    check_eq("cmd8_idx",   64'(ocmd_idx), 64'd8);
    check_eq("cmd8_arg",   64'(ocmd_arg), 64'h1AA);
    respond(1'b0, 32'h000001AA);
    repeat (NCR - 1) tick();
    check_eq("cmd8_gap_en", 64'(ocmd_sd_en), 64'd0);
    tick();
    check_eq("cmd8_start_en", 64'(ocmd_sd_en), 64'd1);
    en_cycles = 0;
    for (int i = 47; i >= 0; i--) begin
      rsp[i] = ocmd_sd;
      if (ocmd_sd_en) en_cycles++;
      tick();
    end
    check_eq("cmd8_rsp",     64'(rsp), 64'h08000001AA13);
    check_eq("cmd8_en_len",  64'(en_cycles), 64'd48);
    check_eq("cmd8_end_en",  64'(ocmd_sd_en), 64'd0);
    check_eq("cmd8_end_sd",  64'(ocmd_sd), 64'd1);
    check_eq("cmd8_end_busy", 64'(obusy), 64'd0);

    // CMD55 with no user decision: times out silently
    send_frame(48'h770000000065);
    check_eq("cmd55_valid", 64'(ocmd_valid), 64'd1);
    check_eq("cmd55_idx",   64'(ocmd_idx), 64'd55);
    snap_a = n_en_rise;
    snap_b = n_err;
    repeat (60) tick();
    check_eq("to_busy_wait", 64'(obusy), 64'd1);
    repeat (10) tick();
    check_eq("to_busy_idle", 64'(obusy), 64'd0);
    check_eq("to_en",        64'(ocmd_sd_en), 64'd0);
    check_eq("to_sd",        64'(ocmd_sd), 64'd1);
    check_eq("to_no_drive",  64'(n_en_rise), 64'(snap_a));
    check_eq("to_no_err",    64'(n_err), 64'(snap_b));

    // End bit 0 is always rejected; decoded fields hold
    send_frame(48'h48000001AA86);
    check_eq("endbit_err",   64'(ocrc_err), 64'd1);
    check_eq("endbit_valid", 64'(ocmd_valid), 64'd0);
    check_eq("endbit_idx",   64'(ocmd_idx), 64'd55);
    tick();
    check_eq("endbit_idle",  64'(obusy), 64'd0);

    // Good end bit, wrong CRC7 (0x42 instead of 0x43)
    send_frame(48'h48000001AA85);
`ifdef CMD_CRC_CHECK_EN
    check_eq("badcrc_err",   64'(ocrc_err), 64'd1);
    check_eq("badcrc_valid", 64'(ocmd_valid), 64'd0);
    check_eq("badcrc_idx",   64'(ocmd_idx), 64'd55);
    tick();
`else
    check_eq("badcrc_err",   64'(ocrc_err), 64'd0);
    check_eq("badcrc_valid", 64'(ocmd_valid), 64'd1);
    check_eq("badcrc_idx",   64'(ocmd_idx), 64'd8);
    respond(1'b1, 32'h0);
`endif
    check_eq("badcrc_idle", 64'(obusy), 64'd0);

    // Reset while frame bit 20 of a response is on the line
    send_frame(48'h48000001AA87);
    respond(1'b0, 32'hDEADBEEF);
    repeat (NCR) tick();
    for (int i = 47; i > 20; i--) begin
      rsp[i] = ocmd_sd;
      tick();
    end
    exp_frame = {2'b00, 6'd8, 32'hDEADBEEF, 8'h00};
    check_eq("rs_partial", 64'(rsp[47:21]), 64'(exp_frame[47:21]));
    check_eq("rs_pre_en",  64'(ocmd_sd_en), 64'd1);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    check_eq("rs_en",   64'(ocmd_sd_en), 64'd0);
    check_eq("rs_sd",   64'(ocmd_sd), 64'd1);
    check_eq("rs_busy", 64'(obusy), 64'd0);
    check_eq("rs_arg",  64'(ocmd_arg), 64'd0);
    tick();
    send_frame(48'h400000000095);
    check_eq("rs_cmd0_valid", 64'(ocmd_valid), 64'd1);
    check_eq("rs_cmd0_idx",   64'(ocmd_idx), 64'd0);
    respond(1'b1, 32'h0);
    check_eq("rs_cmd0_idle",  64'(obusy), 64'd0);

    // Start bit followed by a 0 transmission bit is a glitch
    tick();
    snap_a = n_valid;
    snap_b = n_err;
    icmd_sd = 1'b0;
    tick();
    icmd_sd = 1'b0;
    tick();
    icmd_sd = 1'b1;
    check_eq("glitch_idle", 64'(obusy), 64'd0);
    repeat (50) tick();
    check_eq("glitch_no_valid", 64'(n_valid), 64'(snap_a));
    check_eq("glitch_no_err",   64'(n_err), 64'(snap_b));
    check_eq("glitch_no_drive", 64'(ocmd_sd_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
